// File: rtl/vec_pkg.sv
// vec_pkg -- shared types and defaults for the four-lane operand interface.
//
// Contents:
//   VEC_W        default lane/sample width in bits
//   VEC_N        default lanes per vector
//   lane_t       one lane of VEC_W bits
//   cnt_t        lane count wide enough to hold 0..VEC_N
//   out_state_t  EMPTY/FULL state of the output holding register
package vec_pkg;

  localparam int VEC_W = 8;
  localparam int VEC_N = 4;

  typedef logic [VEC_W-1:0] lane_t;
  typedef logic [$clog2(VEC_N+1)-1:0] cnt_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/vec_out_reg.sv
// vec_out_reg -- output holding register of the vector collector.
//
// Holds one complete (or flushed) vector, its lane count and, when the
// VEC_COLLECT_SUM_EN macro is defined, the registered lane sum. The register
// is EMPTY or FULL. Contents only change on a load edge, so they stay stable
// while FULL and waiting for the consumer.
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset
//   load_i   in   capture data_i/count_i(/sum_i) this edge (caller ensures
//                 the register is empty or being drained on the same edge)
//   data_i   in   N lanes of W bits, lane 0 oldest
//   count_i  in   number of meaningful lanes
//   sum_i    in   lane sum (VEC_COLLECT_SUM_EN only)
//   ready_i  in   consumer accepts the held vector
//   valid_o  out  register is FULL
//   data_o   out  held vector
//   count_o  out  held lane count
//   sum_o    out  held lane sum (VEC_COLLECT_SUM_EN only)
module vec_out_reg
  import vec_pkg::*;
#(
  parameter int W  = VEC_W,
  parameter int N  = VEC_N,
  parameter int CW = $clog2(N+1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [W-1:0]  data_i [N-1:0],
  input  logic [CW-1:0] count_i,
`ifdef VEC_COLLECT_SUM_EN
  input  logic [W-1:0]  sum_i,
  output logic [W-1:0]  sum_o,
`endif
  input  logic          ready_i,
  output logic          valid_o,
  output logic [W-1:0]  data_o [N-1:0],
  output logic [CW-1:0] count_o
);

  out_state_t state_reg;
  out_state_t state_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= OUT_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // A load always leaves the register FULL; a drain without a same-edge
  // load empties it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OUT_EMPTY: begin
        if (load_i) state_next = OUT_FULL;
      end
      OUT_FULL: begin
        if (load_i)       state_next = OUT_FULL;
        else if (ready_i) state_next = OUT_EMPTY;
      end
      default: state_next = OUT_EMPTY;
    endcase
  end

  assign valid_o = (state_reg == OUT_FULL);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          data_o[gi] <= '0;
        end else if (load_i) begin
          data_o[gi] <= data_i[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_o <= '0;
    end else if (load_i) begin
      count_o <= count_i;
    end
  end

`ifdef VEC_COLLECT_SUM_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_o <= '0;
    end else if (load_i) begin
      sum_o <= sum_i;
    end
  end
`endif

endmodule

// File: rtl/vec_collect.sv
// vec_collect -- stream-to-vector collector.
//
// Accepts W-bit samples one per handshake and packs every N consecutive
// samples into an N-lane vector (lane 0 oldest). The first N-1 samples sit in
// an assembly register; the completing sample goes straight into the output
// register together with them, so collection of the next vector continues
// while the current one waits for the consumer. flush_i emits a partially
// filled vector, zero-padded, including any sample accepted on the same edge.
//
// Optional feature (macro VEC_COLLECT_SUM_EN): adds m_sum_o, the modulo-2^W
// sum of all lanes of the loaded vector, registered with the vector.
//
// Ports:
//   clk_i      in   clock, rising edge
//   rst_ni     in   asynchronous active-low reset
//   s_valid_i  in   input sample valid
//   s_data_i   in   input sample (W bits)
//   s_ready_o  out  collector can accept a sample this cycle
//   flush_i    in   emit the partial vector (held until it takes effect)
//   m_valid_o  out  output vector valid
//   m_data_o   out  output vector, N lanes of W bits
//   m_count_o  out  number of meaningful lanes, 1..N
//   m_sum_o    out  lane sum (VEC_COLLECT_SUM_EN only)
//   m_ready_i  in   consumer accepts the vector
module vec_collect
  import vec_pkg::*;
#(
  parameter int W = VEC_W,
  parameter int N = VEC_N
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      s_valid_i,
  input  logic [W-1:0]              s_data_i,
  output logic                      s_ready_o,
  input  logic                      flush_i,
  output logic                      m_valid_o,
  output logic [W-1:0]              m_data_o [N-1:0],
  output logic [$clog2(N+1)-1:0]    m_count_o,
`ifdef VEC_COLLECT_SUM_EN
  output logic [W-1:0]              m_sum_o,
`endif
  input  logic                      m_ready_i
);

  localparam int CW = $clog2(N+1);
  localparam logic [CW-1:0] LAST = CW'(N-1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic [W-1:0]  asm_reg [N-2:0];
  // Assembly lanes padded to N so lane selection needs no range special case.
  logic [W-1:0]  asm_pad [N-1:0];

  logic          load_ok;
  logic          beat;
  logic          complete;
  logic          flush_fire;
  logic          load;
  logic [CW-1:0] eff_cnt;
  logic [W-1:0]  load_data [N-1:0];

  // The output register can take a new vector when it is empty or is
  // being drained on this edge.
  assign load_ok   = !m_valid_o || m_ready_i;
  // Only the completing beat needs space in the output register.
  assign s_ready_o = !(cnt_reg == LAST && !load_ok);
  assign beat      = s_valid_i && s_ready_o;
  assign complete  = beat && (cnt_reg == LAST);
  assign eff_cnt   = cnt_reg + CW'(beat);

  // A completing beat already implies load_ok; a same-edge flush is then
  // absorbed by the full vector.
  assign flush_fire = flush_i && load_ok && (eff_cnt != '0);
  assign load       = complete || flush_fire;

  always_comb begin
    cnt_next = cnt_reg;
    if (load)      cnt_next = '0;
    else if (beat) cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N-1; gi++) begin : g_asm
      // A beat that triggers a load goes directly to the output register,
      // so the assembly lane is only written on non-loading beats.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          asm_reg[gi] <= '0;
        end else if (beat && !load && cnt_reg == CW'(gi)) begin
          asm_reg[gi] <= s_data_i;
        end
      end
      assign asm_pad[gi] = asm_reg[gi];
    end
  endgenerate
  assign asm_pad[N-1] = '0;

  // Lanes below cnt come from assembly, lane cnt takes the same-cycle beat,
  // everything above is zero padding.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      load_data[i] = '0;
      if (CW'(i) < cnt_reg) begin
        load_data[i] = asm_pad[i];
      end else if (beat && CW'(i) == cnt_reg) begin
        load_data[i] = s_data_i;
      end
    end
  end

`ifdef VEC_COLLECT_SUM_EN
  logic [W-1:0] load_sum;

  // Natural W-bit wrap gives the modulo-2^W sum.
  always_comb begin
    load_sum = '0;
    for (int i = 0; i < N; i++) begin
      load_sum = load_sum + load_data[i];
    end
  end
`endif

  vec_out_reg #(
    .W  (W),
    .N  (N),
    .CW (CW)
  ) u_out (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (load),
    .data_i  (load_data),
    .count_i (eff_cnt),
`ifdef VEC_COLLECT_SUM_EN
    .sum_i   (load_sum),
    .sum_o   (m_sum_o),
`endif
    .ready_i (m_ready_i),
    .valid_o (m_valid_o),
    .data_o  (m_data_o),
    .count_o (m_count_o)
  );

endmodule

// File: tb/tb_vec_collect.sv
// tb_vec_collect -- directed bench for vec_collect (W=8, N=4).
//
// A queue-based reference model tracks the samples waiting for a vector and
// the vector currently offered downstream; a compare process checks every
// DUT output against it once per cycle. Literal expectations at key points
// pin the model to hand-computed values.
module tb_vec_collect;

  localparam int W = 8;
  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         s_valid;
  logic [W-1:0] s_data;
  logic         s_ready;
  logic         flush;
  logic         m_valid;
  logic [W-1:0] m_data [N-1:0];
  logic [2:0]   m_count;
  logic         m_ready;
`ifdef VEC_COLLECT_SUM_EN
  logic [W-1:0] m_sum;
`endif

  int vectors = 0;
  int miscompares = 0;

  vec_collect #(.W(W), .N(N)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .s_valid_i (s_valid),
    .s_data_i  (s_data),
    .s_ready_o (s_ready),
    .flush_i   (flush),
    .m_valid_o (m_valid),
    .m_data_o  (m_data),
    .m_count_o (m_count),
`ifdef VEC_COLLECT_SUM_EN
    .m_sum_o   (m_sum),
`endif
    .m_ready_i (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  byte unsigned mq[$];           // accepted samples not yet in a vector
  bit           mv;              // a vector is being offered
  byte unsigned md[N];           // offered vector contents
  int           mc;              // offered lane count
  int           ms;              // offered lane sum mod 256
  bit           m_lok, m_rdy, m_bt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mv = 0;
      mc = 0;
      ms = 0;
      for (int i = 0; i < N; i++) md[i] = 8'h00;
    end else begin
      m_lok = !mv || m_ready;
      m_rdy = !(mq.size() == N-1 && !m_lok);
      m_bt  = s_valid && m_rdy;
      if (m_bt) mq.push_back(s_data);
      if (mq.size() == N || (flush && m_lok && mq.size() > 0)) begin
        mc = mq.size();
        ms = 0;
        for (int i = 0; i < N; i++) begin
          md[i] = (i < mc) ? mq[i] : 8'h00;
          ms = (ms + md[i]) % 256;
        end
        mv = 1;
        mq.delete();
      end else if (m_ready) begin
        mv = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    #2;
    chk("s_ready", s_ready, !(mq.size() == N-1 && mv && !m_ready));
    chk("m_valid", m_valid, mv);
    chk("m_count", m_count, mc);
    for (int i = 0; i < N; i++) chk($sformatf("m_data[%0d]", i), m_data[i], md[i]);
`ifdef VEC_COLLECT_SUM_EN
    chk("m_sum", m_sum, ms);
`endif
  end

  // Drive one cycle of inputs starting at a falling edge; returns at the next.
  task automatic step(input logic v, input logic [W-1:0] d, input logic f, input logic r);
    s_valid = v;
    s_data  = v ? d : 8'h00;
    flush   = f;
    m_ready = r;
    $display("cyc t=%0t valid=%0d data=%02h flush=%0d ready=%0d", $time, v, d, f, r);
    @(negedge clk);
  endtask

  task automatic chk_vec(input string nm, input logic [31:0] cnt,
                         input logic [7:0] l0, input logic [7:0] l1,
                         input logic [7:0] l2, input logic [7:0] l3);
    chk({nm, ".valid"}, m_valid, 1);
    chk({nm, ".count"}, m_count, cnt);
    chk({nm, ".lane0"}, m_data[0], l0);
    chk({nm, ".lane1"}, m_data[1], l1);
    chk({nm, ".lane2"}, m_data[2], l2);
    chk({nm, ".lane3"}, m_data[3], l3);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    flush   = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.s_ready", s_ready, 1);
    chk("reset.m_valid", m_valid, 0);
    chk("reset.m_count", m_count, 0);
    chk("reset.lane0", m_data[0], 0);
    chk("reset.lane3", m_data[3], 0);
    rst_n = 1'b1;

    // Reset then stream
    step(1, 8'h01, 0, 1);
    step(1, 8'h02, 0, 1);
    step(1, 8'h03, 0, 1);
    chk("stream.early_valid", m_valid, 0);
    step(1, 8'h04, 0, 1);
    chk_vec("stream", 4, 8'h01, 8'h02, 8'h03, 8'h04);
`ifdef VEC_COLLECT_SUM_EN
    chk("stream.sum", m_sum, 8'h0A);
`endif
    step(0, 8'h00, 0, 1);
    chk("stream.drained", m_valid, 0);

    // Backpressure
    for (int i = 0; i < 7; i++) step(1, 8'(8'h10 + i), 0, 0);
    chk_vec("bp.held", 4, 8'h10, 8'h11, 8'h12, 8'h13);
    step(1, 8'h17, 0, 0);
    chk("bp.s_ready_low", s_ready, 0);
    step(1, 8'h17, 0, 0);
    chk_vec("bp.still_held", 4, 8'h10, 8'h11, 8'h12, 8'h13);
    step(1, 8'h17, 0, 1);
    chk_vec("bp.second", 4, 8'h14, 8'h15, 8'h16, 8'h17);
    step(0, 8'h00, 0, 1);

    // Flush partial
    step(1, 8'hAA, 0, 1);
    step(1, 8'hBB, 0, 1);
    step(0, 8'h00, 1, 1);
    chk_vec("flush2", 2, 8'hAA, 8'hBB, 8'h00, 8'h00);
    step(0, 8'h00, 0, 1);

    // Flush with same-cycle beat, then flush with nothing collected
    step(1, 8'h11, 0, 1);
    step(1, 8'h22, 0, 1);
    step(1, 8'hCC, 1, 1);
    chk_vec("flush3", 3, 8'h11, 8'h22, 8'hCC, 8'h00);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 1, 1);
    chk("flush0.no_output", m_valid, 0);

    // Flush together with the completing beat
    step(1, 8'h01, 0, 1);
    step(1, 8'h02, 0, 1);
    step(1, 8'h03, 0, 1);
    step(1, 8'h04, 1, 1);
    chk_vec("flush4", 4, 8'h01, 8'h02, 8'h03, 8'h04);
    step(0, 8'h00, 0, 1);

    // Flush held while output is blocked
    for (int i = 0; i < 6; i++) step(1, 8'(8'h31 + i), 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    chk_vec("flushblk.held", 4, 8'h31, 8'h32, 8'h33, 8'h34);
    step(0, 8'h00, 1, 1);
    chk_vec("flushblk.go", 2, 8'h35, 8'h36, 8'h00, 8'h00);
    step(0, 8'h00, 0, 1);

    // Sum wrap
    step(1, 8'hFF, 0, 1);
    step(1, 8'hFF, 0, 1);
    step(1, 8'h01, 0, 1);
    step(1, 8'h01, 0, 1);
    chk_vec("wrap", 4, 8'hFF, 8'hFF, 8'h01, 8'h01);
`ifdef VEC_COLLECT_SUM_EN
    chk("wrap.sum", m_sum, 8'h00);
`endif
    step(0, 8'h00, 0, 1);

    // Reset mid-operation with a pending vector and two partial lanes
    for (int i = 0; i < 6; i++) step(1, 8'(8'h41 + i), 0, 0);
    s_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("midrst.m_valid", m_valid, 0);
    chk("midrst.s_ready", s_ready, 1);
    chk("midrst.m_count", m_count, 0);
    chk("midrst.lane0", m_data[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'h05, 0, 1);
    step(1, 8'h06, 0, 1);
    step(1, 8'h07, 0, 1);
    step(1, 8'h08, 0, 1);
    chk_vec("midrst.after", 4, 8'h05, 8'h06, 8'h07, 8'h08);
    step(0, 8'h00, 0, 1);

    // Mixed traffic, checked by the model
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 1)));
    end
    step(0, 8'h00, 1, 1);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
